// File: rtl/spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter
//
// Lets NUM_REQ client requesters share one SPI master. The SPI master uses a
// start/finish/data_in/data_out handshake. Requesters are served round-robin.
// Each requester has its own active-low chip select, with programmable setup
// and hold times around the SPI frame. The received frame is returned to the
// requester that owns the current transfer.
//
// Transfer sequence: IDLE -> SETUP -> START -> WAIT -> HOLD -> DONE -> IDLE.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous reset, active HIGH (kept from the existing code)
//   req           level request, one bit per requester
//   req_data      tx frames; requester i is at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant         one-hot owner of the SPI master (SETUP..HOLD)
//   ack           one-cycle pulse to the owner in DONE; rsp_data is valid then
//   rsp_data      received frame, held until the next DONE
//   busy          high in every state except IDLE
//   cs_n          active-low chip selects, bit i belongs to requester i
//   spi_start     one-cycle start pulse to the SPI master
//   spi_data_in   tx frame to the SPI master, registered at grant
//   spi_finish    one-cycle done pulse from the SPI master
//   spi_data_out  rx frame from the SPI master, valid with spi_finish
//   timeout_err   pulses together with ack when the WAIT watchdog aborted
//
// Build option
//   SPI_ARB_TIMEOUT_EN  When defined, adds a WAIT watchdog of TIMEOUT_CYC
//                       cycles. An aborted transfer returns an all-ones frame.
//                       When undefined, WAIT waits forever and timeout_err is 0.
// -----------------------------------------------------------------------------
module spi_master_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy,
    output logic [NUM_REQ-1:0]            cs_n,
    output logic                          spi_start,
    output logic [DATA_WIDTH-1:0]         spi_data_in,
    input  logic                          spi_finish,
    input  logic [DATA_WIDTH-1:0]         spi_data_out,
    output logic                          timeout_err
);

    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PHASE_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int CNT_W     = $clog2(PHASE_MAX + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || CS_SETUP_CYC < 1 || CS_HOLD_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("spi_master_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        win_idx;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [NUM_REQ-1:0]      owner_oh;
    logic [CNT_W-1:0]        phase_cnt;
    logic [DATA_WIDTH-1:0]   rx_frame;
    logic                    wait_expired;
    logic                    timed_out;

    // Round-robin pick: the first set request at or above p, wrapping.
    // The request vector is doubled and rotated down by p. After that, the
    // winner is simply the lowest set bit, offset by p.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
        logic [2*NUM_REQ-1:0] rot;
        logic [IDX_W-1:0]     pick;
        logic                 found;
        int                   sum;
        rot   = {r, r} >> p;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                sum = int'(p) + i;
                if (sum >= NUM_REQ) sum = sum - NUM_REQ;
                pick  = IDX_W'(sum);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        win_idx  = rr_pick(req, ptr);
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] wait_cnt;

    // wait_cnt holds the number of WAIT cycles already spent. A limit of
    // TIMEOUT_CYC therefore expires on the last allowed WAIT cycle.
    assign wait_expired = (state == S_WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
            if (state == S_IDLE && |req) begin
                timed_out <= 1'b0;
            end else if (state == S_WAIT && !spi_finish && wait_expired) begin
                // A finish in the same cycle as the limit is a normal completion.
                timed_out <= 1'b1;
            end
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timed_out    = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|req) state_nxt = S_SETUP;
            S_SETUP: if (phase_cnt == CNT_W'(CS_SETUP_CYC - 1)) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (spi_finish || wait_expired) state_nxt = S_HOLD;
            S_HOLD:  if (phase_cnt == CNT_W'(CS_HOLD_CYC - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs. These are decoded from the registered state and owner,
    // so an asynchronous reset clears them at once.
    assign owner_oh = NUM_REQ'(1) << owner;

    always_comb begin
        grant       = '0;
        cs_n        = '1;
        ack         = '0;
        spi_start   = 1'b0;
        busy        = (state != S_IDLE);
        timeout_err = 1'b0;
        case (state)
            S_SETUP, S_WAIT, S_HOLD: begin
                grant = owner_oh;
                cs_n  = ~owner_oh;
            end
            S_START: begin
                grant     = owner_oh;
                cs_n      = ~owner_oh;
                spi_start = 1'b1;
            end
            S_DONE: begin
                ack         = owner_oh;
                timeout_err = timed_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            // NOTE: the datapath registers are reset as well, so rsp_data and spi_data_in read 0 out of reset.
            state       <= S_IDLE;
            owner       <= '0;
            ptr         <= '0;
            phase_cnt   <= '0;
            spi_data_in <= '0;
            rx_frame    <= '0;
            rsp_data    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            state <= state_nxt;

            // phase_cnt restarts on every state change. It counts only in
            // SETUP and HOLD.
            if (state_nxt != state) begin
                phase_cnt <= '0;
            end else if (state == S_SETUP || state == S_HOLD) begin
                phase_cnt <= phase_cnt + 1'b1;
            end

            if (state == S_IDLE && |req) begin
                owner       <= win_idx;
                ptr         <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                spi_data_in <= win_data;
            end

            if (state == S_WAIT) begin
                if (spi_finish) begin
                    rx_frame <= spi_data_out;
                end else if (wait_expired) begin
                    rx_frame <= '1;
                end
            end

            if (state == S_HOLD && state_nxt == S_DONE) begin
                rsp_data <= rx_frame;
            end
        end
    end

endmodule
